// File: rtl/booth_radix4_seq_mult.sv
// Sequential signed multiplier: radix-4 Booth recoding of the multiplier,
// one triplet per cycle, partial products accumulated at weight 4^i.
module booth_radix4_seq_mult #(
  parameter int WIDTH_DATA = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [WIDTH_DATA-1:0]     i_multiplicand,
  input  logic [WIDTH_DATA-1:0]     i_multiplier,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [2*WIDTH_DATA-1:0]   o_product,
  output logic [2:0]                o_sel
);

  localparam int STEPS = WIDTH_DATA / 2;
  localparam int CW    = $clog2(STEPS);
  localparam int PW    = 2 * WIDTH_DATA;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [WIDTH_DATA-1:0] m_reg;
  logic [WIDTH_DATA-1:0] q_reg;
  logic [PW-1:0]         acc;
  logic [CW-1:0]         count;

  logic [WIDTH_DATA:0]   q_ext;
  logic [2:0]            sel_cur;
  logic [PW-1:0]         m_wide;
  logic [PW-1:0]         pp;
  logic [PW-1:0]         acc_next;

  // Partial products are formed at full product width, so -2M stays exact
  // even for the most-negative multiplicand.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_cur = 3'b000;
    q_ext   = {q_reg, 1'b0};
    for (int i = 0; i < STEPS; i++) begin
      if (count == CW'(i)) sel_cur = q_ext[2*i +: 3];
    end
    m_wide = {{WIDTH_DATA{m_reg[WIDTH_DATA-1]}}, m_reg};
    case (sel_cur)
      3'b001, 3'b010: pp = m_wide;
      3'b011:         pp = m_wide << 1;
      3'b100:         pp = -(m_wide << 1);
      3'b101, 3'b110: pp = -m_wide;
      default:        pp = '0;
    endcase
    acc_next = acc + (pp << {count, 1'b0});
  end

  assign o_sel = (state == RUN) ? sel_cur : 3'b000;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_product <= '0;
      m_reg     <= '0;
      q_reg     <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            m_reg   <= i_multiplicand;
            q_reg   <= i_multiplier;
            acc     <= '0;
            count   <= '0;
            o_ready <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            o_product <= acc_next;
            o_valid   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Product is held until downstream takes it; no new accept here.
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Self-checking bench for booth_radix4_seq_mult: directed boundary cases plus
// randomized back-to-back operands compared against plain signed arithmetic.
module tb_booth_radix4_seq_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           i_rst;
  logic           i_valid;
  logic           o_ready;
  logic [W-1:0]   i_multiplicand;
  logic [W-1:0]   i_multiplier;
  logic           o_valid;
  logic           i_ready;
  logic [2*W-1:0] o_product;
  logic [2:0]     o_sel;

  int vectors     = 0;
  int miscompares = 0;

  booth_radix4_seq_mult #(.WIDTH_DATA(W)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_product      (o_product),
    .o_sel          (o_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    int p;
    p = $signed(m) * $signed(q);
    return p[2*W-1:0];
  endfunction

  // Booth triplet i is {Q[2i+1],Q[2i],Q[2i-1]} with Q[-1]=0.
  function automatic logic [2:0] ref_sel(input logic [W-1:0] q, input int i);
    logic [W:0] qe;
    qe = {q, 1'b0};
    return qe[2*i +: 3];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; the next rising edge accepts the pair.
  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
    chk("ready_at_accept", 32'(o_ready), 32'd1);
    chk("no_dup_valid", 32'(o_valid), 32'd0);
    i_valid        = 1'b1;
    i_multiplicand = m;
    i_multiplier   = q;
  endtask

  // mode 0: quiet inputs; 1: i_valid held high with garbage operands;
  // 2: i_valid toggled randomly with garbage operands.
  task automatic wait_result(input string tag, input logic [2*W-1:0] exp, input int mode);
    int lat;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mode == 0) begin
        i_valid = 1'b0;
      end else begin
        i_valid        = (mode == 1) ? 1'b1 : 1'($urandom);
        i_multiplicand = W'($urandom);
        i_multiplier   = W'($urandom);
      end
      if (o_valid) begin
        lat = c;
        break;
      end
      chk({tag, "_ready_run"}, 32'(o_ready), 32'd0);
    end
    chk({tag, "_latency"}, lat, W/2 + 1);
    chk({tag, "_product"}, 32'(o_product), 32'(exp));
  endtask

  initial begin
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] held;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_multiplicand = '0; i_multiplier = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",   32'(o_ready),   32'd1);
    chk("rst_valid",   32'(o_valid),   32'd0);
    chk("rst_product", 32'(o_product), 32'd0);
    chk("rst_sel",     32'(o_sel),     32'd0);
    i_rst = 1'b0;
    @(negedge clk);

    // Small positive pair: triplet sequence and exact latency.
    start_op(8'd3, 8'd5);
    for (int i = 0; i < W/2; i++) begin
      @(negedge clk);
      i_valid = 1'b0;
      chk($sformatf("t1_sel%0d", i), 32'(o_sel), 32'(ref_sel(8'd5, i)));
      chk("t1_valid_run", 32'(o_valid), 32'd0);
    end
    @(negedge clk);
    chk("t1_valid", 32'(o_valid), 32'd1);
    chk("t1_product", 32'(o_product), 32'd15);
    chk("t1_sel_done", 32'(o_sel), 32'd0);
    @(negedge clk);

    // Most-negative operands and sign corners.
    start_op(8'h80, 8'h80); wait_result("t2_minmin", 16'h4000, 0); @(negedge clk);
    start_op(8'd127, 8'h80); wait_result("t2_maxmin", 16'hC080, 0); @(negedge clk);
    start_op(8'hFF, 8'hFF); wait_result("t2_m1m1", 16'h0001, 0); @(negedge clk);
    start_op(8'h80, 8'd127); wait_result("t2_minmax", 16'hC080, 0); @(negedge clk);
    start_op(8'h80, 8'h01); wait_result("t2_min1", 16'hFF80, 0); @(negedge clk);
    start_op(8'h00, 8'h80); wait_result("t2_zero", 16'h0000, 0); @(negedge clk);

    // Backpressure: product held while downstream stalls.
    start_op(8'd20, 8'hFD);
    wait_result("t3", ref_mul(8'd20, 8'hFD), 0);
    i_ready = 1'b0;
    held = o_product;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(o_valid), 32'd1);
      chk("t3_hold_product", 32'(o_product), 32'(held));
      chk("t3_hold_ready", 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_valid", 32'(o_valid), 32'd0);
    chk("t3_release_ready", 32'(o_ready), 32'd1);

    // Reset during the second RUN cycle discards the operation.
    start_op(8'd100, 8'd100);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("t4_ready", 32'(o_ready), 32'd1);
    chk("t4_valid", 32'(o_valid), 32'd0);
    chk("t4_product", 32'(o_product), 32'd0);
    chk("t4_sel", 32'(o_sel), 32'd0);
    start_op(8'hF9, 8'd9); wait_result("t4_after", 16'hFFC1, 0); @(negedge clk);

    // Noisy inputs during RUN and a stalled DONE must not disturb the result.
    for (int n = 0; n < 8; n++) begin
      m = W'($urandom); q = W'($urandom);
      start_op(m, q);
      wait_result("t6", ref_mul(m, q), 2);
      i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        i_valid = 1'b1;
        i_multiplicand = W'($urandom);
        i_multiplier   = W'($urandom);
        chk("t6_done_ready", 32'(o_ready), 32'd0);
        chk("t6_done_product", 32'(o_product), 32'(ref_mul(m, q)));
      end
      i_ready = 1'b1;
      i_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end

    // Back-to-back random pairs with i_valid held high throughout; the
    // latency check plus the IDLE re-check pins accept spacing at W/2+2.
    for (int n = 0; n < 1000; n++) begin
      m = W'($urandom); q = W'($urandom);
      start_op(m, q);
      wait_result("t5", ref_mul(m, q), 1);
      @(negedge clk);
    end
    i_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
